// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter, clean level and
// registered one-cycle rise/fall strobes, with an optional sample-enable tick.
module debounce_multi #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned THRESHOLD   = 20,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_en,
   input  logic [CHANNELS-1:0] noisy_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

   logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
   logic [CHANNELS-1:0]                  sync_s;
   logic [CHANNELS-1:0][CNT_W-1:0]       count_q;
   logic [CHANNELS-1:0][CNT_W-1:0]       count_d;
   logic [CHANNELS-1:0]                  clean_d;
   logic [CHANNELS-1:0]                  rise_d;
   logic [CHANNELS-1:0]                  fall_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            sync_q[i] <= {SYNC_STAGES{RESET_VAL}};
         end else begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], noisy_in[i]};
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         sync_s[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      clean_d = clean_out;
      rise_d  = '0;
      fall_d  = '0;
      count_d = count_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sync_s[i] == clean_out[i]) begin
            // A bounce back to the accepted level abandons any pending change.
            count_d[i] = '0;
         end else if (sample_en) begin
            if (count_q[i] == CNT_LAST) begin
               count_d[i] = '0;
               clean_d[i] = sync_s[i];
               rise_d[i]  = sync_s[i];
               fall_d[i]  = ~sync_s[i];
            end else begin
               count_d[i] = count_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // NOTE: the counters are ordinary per-channel registers, not a RAM, so they take the reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         clean_out  <= {CHANNELS{RESET_VAL}};
         rise       <= '0;
         fall       <= '0;
         any_change <= 1'b0;
      end else begin
         count_q    <= count_d;
         clean_out  <= clean_d;
         rise       <= rise_d;
         fall       <= fall_d;
         any_change <= |(rise_d | fall_d);
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: a THRESHOLD=20 and a THRESHOLD=1 build share stimulus and
// are checked every cycle against a run-length reference model.
module tb_debounce_multi;

   localparam int CH   = 4;
   localparam int SYNC = 2;
   localparam int T0   = 20;
   localparam int T1   = 1;

   typedef struct packed {
      logic [CH-1:0] clean;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic          any;
   } out_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sample_en = 1'b1;
   logic [CH-1:0] noisy_in = '0;

   logic [CH-1:0] clean0, rise0, fall0, clean1, rise1, fall1;
   logic          any0, any1;

   int passed = 0;
   int total  = 0;

   out_t sb0[$];
   out_t sb1[$];
   logic started = 1'b0;
   logic done    = 1'b0;

   logic [CH-1:0] hist[$];
   logic [CH-1:0] m_clean[2];
   int            run[2][CH];

   logic [CH-1:0] obs_rise;

   always #5 clk = ~clk;

   debounce_multi #(.CHANNELS(CH), .CNT_W(16), .THRESHOLD(T0), .SYNC_STAGES(SYNC), .RESET_VAL(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .sample_en(sample_en), .noisy_in(noisy_in),
      .clean_out(clean0), .rise(rise0), .fall(fall0), .any_change(any0)
   );

   debounce_multi #(.CHANNELS(CH), .CNT_W(4), .THRESHOLD(T1), .SYNC_STAGES(SYNC), .RESET_VAL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .sample_en(sample_en), .noisy_in(noisy_in),
      .clean_out(clean1), .rise(rise1), .fall(fall1), .any_change(any1)
   );

   task automatic check(input string name, input out_t got, input out_t exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s @%0t: got clean=%b rise=%b fall=%b any=%b, required clean=%b rise=%b fall=%b any=%b",
                    name, $time, got.clean, got.rise, got.fall, got.any, exp.clean, exp.rise, exp.fall, exp.any);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, got, exp);
   endtask

   // Reference: a change is accepted once the synchronised input has disagreed with the accepted
   // level for THRESHOLD enabled samples in a row; the synchroniser is a SYNC-deep delay line.
   task automatic model_edge(input logic r, input logic e, input logic [CH-1:0] n);
      out_t          exp[2];
      logic [CH-1:0] s;
      int            thr;
      if (r) begin
         hist.delete();
         repeat (SYNC) hist.push_back('0);
         for (int k = 0; k < 2; k++) begin
            m_clean[k] = '0;
            for (int c = 0; c < CH; c++) run[k][c] = 0;
            exp[k] = '0;
         end
      end else begin
         s = hist.pop_front();
         hist.push_back(n);
         for (int k = 0; k < 2; k++) begin
            thr = (k == 0) ? T0 : T1;
            exp[k] = '0;
            for (int c = 0; c < CH; c++) begin
               if (s[c] == m_clean[k][c]) run[k][c] = 0;
               else if (e) begin
                  run[k][c]++;
                  if (run[k][c] == thr) begin
                     run[k][c] = 0;
                     m_clean[k][c] = s[c];
                     if (s[c]) exp[k].rise[c] = 1'b1;
                     else      exp[k].fall[c] = 1'b1;
                  end
               end
            end
            exp[k].clean = m_clean[k];
            exp[k].any   = |(exp[k].rise | exp[k].fall);
         end
      end
      sb0.push_back(exp[0]);
      sb1.push_back(exp[1]);
      started = 1'b1;
   endtask

   // Drives inputs for the next rising edge; obs_rise holds what the DUT showed after the previous edge.
   task automatic step(input logic r, input logic e, input logic [CH-1:0] n);
      @(negedge clk);
      obs_rise  = rise0;
      rst       = r;
      sample_en = e;
      noisy_in  = n;
      model_edge(r, e, n);
   endtask

   task automatic hold(input int cycles, input logic [CH-1:0] n);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, n);
   endtask

   task automatic measure_rise0(input string name, input logic [CH-1:0] n);
      int first = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1'b0, 1'b1, n);
         if (obs_rise[0] && first == 0) first = k;
      end
      check_int(name, first, SYNC + T0);
   endtask

   initial begin : monitor
      out_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb0.size() > 0) begin
            e = sb0.pop_front();
            check("thr20", {clean0, rise0, fall0, any0}, e);
         end else if (started && !done) check_int("thr20_queue_empty", 0, 1);
         if (sb1.size() > 0) begin
            e = sb1.pop_front();
            check("thr1", {clean1, rise1, fall1, any1}, e);
         end else if (started && !done) check_int("thr1_queue_empty", 0, 1);
      end
   end

   initial begin : stimulus
      logic [CH-1:0] n;
      repeat (3) step(1'b1, 1'b1, '0);

      // Clean 0->1 on channel 0; acceptance on edge SYNC+THRESHOLD.
      step(1'b0, 1'b1, 4'b0001);
      measure_rise0("latency_ch0", 4'b0001);

      // Bounce on channel 1 after 10 samples.
      hold(SYNC + 10, 4'b0011);
      step(1'b0, 1'b1, 4'b0001);
      hold(30, 4'b0011);

      // Channel 2 up, then down with sample_en one cycle in four.
      hold(25, 4'b0111);
      for (int k = 0; k < 100; k++) step(1'b0, (k % 4) == 3, 4'b0011);

      // Channels 0 and 3 switch together.
      hold(30, 4'b0000);
      hold(30, 4'b1001);

      // Reset in the middle of a pending 0->1 on channel 0.
      hold(30, 4'b0000);
      hold(SYNC + 15, 4'b0001);
      repeat (2) step(1'b1, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0001);
      measure_rise0("latency_after_reset", 4'b0001);

      // One-cycle glitch on channel 1 for the THRESHOLD=1 build.
      hold(10, 4'b0000);
      step(1'b0, 1'b1, 4'b0010);
      hold(10, 4'b0000);

      // Randomised phase: sparse toggles, random enable, rare resets.
      n = '0;
      for (int k = 0; k < 2000; k++) begin
         for (int c = 0; c < CH; c++) if ($urandom_range(24) == 0) n[c] = ~n[c];
         step($urandom_range(299) == 0, $urandom_range(3) != 0, n);
      end

      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
